// File: rtl/led_fade_sequencer.sv
// LED duty-cycle sequencer: derives a slow update tick from the system clock
// and steps a duty word through OFF / ON / BREATHE / SAW lighting modes.
module led_fade_sequencer #(
    parameter int RESOLUTION = 8,
    parameter int TICK_DIV   = 135000,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 50
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_mode_pulse,
    output logic [RESOLUTION-1:0] o_duty,
    output logic [1:0]            o_mode,
    output logic [1:0]            o_phase,
    output logic                  o_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0]         PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_TICKS - 1);
    // Duty arithmetic carries one spare bit so a step past DMAX is visible.
    localparam logic [RESOLUTION:0]   DMAX_W    = {1'b0, {RESOLUTION{1'b1}}};
    localparam logic [RESOLUTION:0]   STEP_W    = (RESOLUTION + 1)'(STEP);
    localparam logic [RESOLUTION-1:0] STEP_N    = RESOLUTION'(STEP);
    localparam logic [RESOLUTION-1:0] DMAX_N    = {RESOLUTION{1'b1}};

    typedef enum logic [1:0] {M_OFF, M_ON, M_BREATHE, M_SAW} mode_t;
    typedef enum logic [1:0] {PH_UP, PH_HOLD_HI, PH_DOWN, PH_HOLD_LO} phase_t;

    logic [PW-1:0]         pre_cnt;
    logic [HW-1:0]         hold_cnt;
    mode_t                 mode;
    phase_t                phase;
    logic [RESOLUTION-1:0] duty;
    logic [RESOLUTION:0]   duty_up;
    logic [RESOLUTION-1:0] duty_dn;
    logic                  step_en;

    assign duty_up = {1'b0, duty} + STEP_W;
    assign duty_dn = duty - STEP_N;
    // A mode pulse wins over a pending tick; disabled sequencing freezes the FSM.
    assign step_en = o_tick && i_enable && !i_mode_pulse;

    assign o_duty  = duty;
    assign o_mode  = mode;
    assign o_phase = phase;

    // Prescaler: wraps at TICK_DIV-1 and strobes o_tick on the following cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre_cnt <= '0;
            o_tick  <= 1'b0;
        end else if (i_mode_pulse) begin
            pre_cnt <= '0;
            o_tick  <= 1'b0;
        end else if (i_enable) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                o_tick  <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                o_tick  <= 1'b0;
            end
        end else begin
            o_tick <= 1'b0;
        end
    end

    // Mode/phase FSM and duty update, advancing one step per tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode     <= M_OFF;
            phase    <= PH_UP;
            hold_cnt <= '0;
            duty     <= '0;
        end else if (i_mode_pulse) begin
            mode     <= mode_t'(mode + 2'd1);
            phase    <= PH_UP;
            hold_cnt <= '0;
            // Only the OFF -> ON transition enters at full brightness.
            duty     <= (mode == M_OFF) ? DMAX_N : '0;
        end else if (step_en) begin
            case (mode)
                M_BREATHE: begin
                    case (phase)
                        PH_UP: begin
                            if (duty_up >= DMAX_W) begin
                                duty     <= DMAX_N;
                                phase    <= PH_HOLD_HI;
                                hold_cnt <= '0;
                            end else begin
                                duty <= duty_up[RESOLUTION-1:0];
                            end
                        end
                        PH_HOLD_HI: begin
                            if (hold_cnt == HOLD_LAST) begin
                                phase    <= PH_DOWN;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        PH_DOWN: begin
                            if ({1'b0, duty} <= STEP_W) begin
                                duty     <= '0;
                                phase    <= PH_HOLD_LO;
                                hold_cnt <= '0;
                            end else begin
                                duty <= duty_dn;
                            end
                        end
                        default: begin
                            if (hold_cnt == HOLD_LAST) begin
                                phase    <= PH_UP;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    endcase
                end
                M_SAW: begin
                    phase <= PH_UP;
                    if (duty_up > DMAX_W) duty <= '0;
                    else                  duty <= duty_up[RESOLUTION-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with a 4-bit duty, 4-clock tick,
// step of 4 and a two-tick dwell.
module tb_led_fade_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_enable;
    logic       i_mode_pulse;
    logic [3:0] o_duty;
    logic [1:0] o_mode;
    logic [1:0] o_phase;
    logic       o_tick;

    int checks = 0;
    int errors = 0;

    led_fade_sequencer #(
        .RESOLUTION(4), .TICK_DIV(4), .STEP(4), .HOLD_TICKS(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .i_mode_pulse(i_mode_pulse), .o_duty(o_duty), .o_mode(o_mode),
        .o_phase(o_phase), .o_tick(o_tick)
    );

    always #5 i_clk = ~i_clk;

    // Waits (bounded) for a negedge where o_tick is high.
    task automatic wait_tick(input string name);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_tick) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: tick timeout, got none, want one within 20 clocks", name);
        end
    endtask

    // Waits for a tick then moves to the cycle where its duty update is visible.
    task automatic step(input string name);
        wait_tick(name);
        @(negedge i_clk);
    endtask

    task automatic pulse_mode();
        @(negedge i_clk);
        i_mode_pulse = 1'b1;
        @(negedge i_clk);
        i_mode_pulse = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_enable = 1'b0; i_mode_pulse = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_duty, o_mode, o_phase, o_tick} !== 9'd0) begin
            errors++;
            $display("FAIL reset: duty=%0d mode=%0d phase=%0d tick=%0d, want all 0",
                     o_duty, o_mode, o_phase, o_tick);
        end
        i_rst = 1'b0;
        i_enable = 1'b1;
    endtask

    task automatic test_tick_period();
        int n = 0;
        wait_tick("tick_period_first");
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_tick && n < 20);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL tick_period: got %0d clocks, want 4", n);
        end
    endtask

    task automatic test_modes();
        int exp_m[4] = '{1, 2, 3, 0};
        int exp_d[4] = '{15, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            pulse_mode();
            checks++;
            if (o_mode !== 2'(exp_m[k]) || o_duty !== 4'(exp_d[k])) begin
                errors++;
                $display("FAIL mode_step%0d: mode=%0d duty=%0d, want mode=%0d duty=%0d",
                         k, o_mode, o_duty, exp_m[k], exp_d[k]);
            end
            repeat (18) @(negedge i_clk);
            if (k == 0) begin
                checks++;
                if (o_duty !== 4'd15) begin
                    errors++;
                    $display("FAIL on_constant: duty=%0d, want 15", o_duty);
                end
            end
        end
    endtask

    task automatic test_breathe();
        int exp_d[13] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0, 4};
        int exp_p[13] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0, 0};
        pulse_mode();
        pulse_mode();
        checks++;
        if (o_mode !== 2'd2 || o_duty !== 4'd0) begin
            errors++;
            $display("FAIL breathe_entry: mode=%0d duty=%0d, want mode=2 duty=0", o_mode, o_duty);
        end
        for (int k = 0; k < 13; k++) begin
            step("breathe");
            checks++;
            if (o_duty !== 4'(exp_d[k]) || o_phase !== 2'(exp_p[k])) begin
                errors++;
                $display("FAIL breathe_tick%0d: duty=%0d phase=%0d, want duty=%0d phase=%0d",
                         k, o_duty, o_phase, exp_d[k], exp_p[k]);
            end
        end
    endtask

    task automatic test_saw();
        int exp_d[5] = '{4, 8, 12, 0, 4};
        pulse_mode();
        checks++;
        if (o_mode !== 2'd3 || o_duty !== 4'd0) begin
            errors++;
            $display("FAIL saw_entry: mode=%0d duty=%0d, want mode=3 duty=0", o_mode, o_duty);
        end
        for (int k = 0; k < 5; k++) begin
            step("saw");
            checks++;
            if (o_duty !== 4'(exp_d[k]) || o_phase !== 2'd0) begin
                errors++;
                $display("FAIL saw_tick%0d: duty=%0d phase=%0d, want duty=%0d phase=0",
                         k, o_duty, o_phase, exp_d[k]);
            end
        end
    endtask

    task automatic test_pulse_on_wrap();
        int n = 0;
        pulse_mode();   // 3 -> 0
        pulse_mode();   // 0 -> 1
        pulse_mode();   // 1 -> 2
        wait_tick("wrap_align");
        repeat (3) @(negedge i_clk);
        i_mode_pulse = 1'b1;      // prescaler sits at its last count here
        @(negedge i_clk);
        i_mode_pulse = 1'b0;
        checks++;
        if (o_mode !== 2'd3 || o_duty !== 4'd0 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse: mode=%0d duty=%0d tick=%0d, want mode=3 duty=0 tick=0",
                     o_mode, o_duty, o_tick);
        end
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_tick && n < 20);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL wrap_next_tick: got %0d clocks, want 4", n);
        end
        @(negedge i_clk);
        checks++;
        if (o_duty !== 4'd4) begin
            errors++;
            $display("FAIL wrap_first_step: duty=%0d, want 4", o_duty);
        end
    endtask

    task automatic test_enable_and_async_reset();
        bit bad = 0;
        pulse_mode();   // 3 -> 0
        pulse_mode();   // 0 -> 1
        pulse_mode();   // 1 -> 2
        step("en_ramp");
        step("en_ramp");
        checks++;
        if (o_duty !== 4'd8) begin
            errors++;
            $display("FAIL enable_pre: duty=%0d, want 8", o_duty);
        end
        i_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_duty !== 4'd8 || o_tick !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL enable_freeze: duty=%0d tick=%0d, want duty=8 tick=0", o_duty, o_tick);
        end
        i_enable = 1'b1;
        step("en_resume");
        checks++;
        if (o_duty !== 4'd12 || o_phase !== 2'd0) begin
            errors++;
            $display("FAIL enable_resume: duty=%0d phase=%0d, want duty=12 phase=0", o_duty, o_phase);
        end
        step("en_sat");
        checks++;
        if (o_duty !== 4'd15 || o_phase !== 2'd1) begin
            errors++;
            $display("FAIL hold_hi_entry: duty=%0d phase=%0d, want duty=15 phase=1", o_duty, o_phase);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_duty, o_mode, o_phase, o_tick} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: duty=%0d mode=%0d phase=%0d tick=%0d, want all 0",
                     o_duty, o_mode, o_phase, o_tick);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_modes();
        test_breathe();
        test_saw();
        test_pulse_on_wrap();
        test_enable_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
